mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
Sequencer between the CPU execute stage and the two RV32M datapaths: the radix-4 multiplier and the iterative divider. It accepts one M-extension op per valid/ready handshake and decodes funct3 into the unit's type code. It issues the op to the right unit, captures the result and returns it on a valid/ready response channel. Divide-by-zero and signed overflow are resolved locally without invoking the divider; a flush aborts or drains the in-flight op.

Parameters:
TAG_W, 5, width of destination-register tag carried from request to response
FAST_DIV, 1, 1 = resolve div-by-zero/overflow locally; 0 = always issue to divider

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  CPU op valid
req_ready  out  1  controller can accept op
req_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
req_rs1  in  32  operand rs1
req_rs2  in  32  operand rs2
req_tag  in  TAG_W  rd tag
resp_valid  out  1  result valid
resp_ready  in  1  CPU accepts result
resp_data  out  32  result
resp_tag  out  TAG_W  tag of result
cpu_flush  in  1  kill in-flight op
mul_in_valid  out  1  start multiplier
mul_type  out  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
mul_multiplicand  out  32  = rs1
mul_multiplier  out  32  = rs2
mul_cpu_busy  out  1  hold multiplier in done; tied 0
mul_out  in  32  multiplier result
mul_out_valid  in  1  multiplier result valid
mul_busy  in  1  multiplier busy
div_in_valid  out  1  start divider
div_type  out  2  bit0 = unsigned, bit1 = remainder
div_dividend  out  32  = rs1
div_divisor  out  32  = rs2
div_out  in  32  divider result
div_out_valid  in  1  divider result valid
div_busy  in  1  divider busy

Behaviour:
- Reset (synchronous, active-high): state IDLE. All outputs 0: req_ready, resp_valid, resp_data, resp_tag, mul_in_valid, div_in_valid, types and operands. Operand/tag registers cleared.
- rst mid-operation: controller returns to IDLE next cycle. Any later mul_out_valid/div_out_valid is ignored in IDLE.
- States: IDLE, MUL_ISSUE, MUL_WAIT, DIV_ISSUE, DIV_WAIT, RESP, DRAIN.
- req_ready = (state == IDLE) && !cpu_flush. Accept when req_valid && req_ready; register funct3, rs1, rs2 and tag.
- Transitions on accept:
  - funct3[2] = 0: go to MUL_ISSUE.
  - funct3[2] = 1 with a fast case (FAST_DIV = 1): go directly to RESP, loading the fast result.
  - Any other divide: go to DIV_ISSUE.
- Fast cases:
  - rs2 == 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
  - Signed op (DIV/REM) with rs1 == 0x80000000 and rs2 == 0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
  - Fast-path latency: resp_valid in the cycle after acceptance.
- MUL_ISSUE / DIV_ISSUE:
  - mul_in_valid (div_in_valid) = !mul_busy (!div_busy) in that state, with operands and type held stable.
  - Advance to MUL_WAIT (DIV_WAIT) the cycle the valid is asserted. Exactly one start pulse per op.
- MUL_WAIT / DIV_WAIT:
  - On the first *_out_valid cycle, capture *_out into resp_data and go to RESP.
  - Any further *_out_valid cycles are ignored.
- RESP:
  - resp_valid = 1; resp_data and resp_tag held stable until resp_ready.
  - On resp_valid && resp_ready, go to IDLE (no same-cycle accept).
- cpu_flush (priority over every other event in the same cycle):
  - In ISSUE or RESP: go to IDLE; nothing is issued; resp_valid drops next cycle.
  - In WAIT: go to DRAIN. DRAIN waits for *_out_valid, discards it, then goes to IDLE.
  - In DRAIN or IDLE: no effect.
- req_ready is 0 in every state except IDLE. The response tag always equals the accepted request's tag.

Test Plan:
- MULHU rs1 = 0xFFFFFFFF, rs2 = 0xFFFFFFFF, tag 7 -> single mul_in_valid pulse, mul_type = 11, resp_data = 0xFFFFFFFE, resp_tag = 7. Same operands with MULH -> 0x00000000; with MUL -> 0x00000001.
- DIV rs1 = 7, rs2 = 0 -> div_in_valid never asserted, resp_valid in the cycle after accept, data 0xFFFFFFFF. REMU 7/0 -> 7.
- REM rs1 = 0x80000000, rs2 = 0xFFFFFFFF -> resp_data 0 with no divider start. DIV with same operands -> 0x80000000. With FAST_DIV = 0 -> divider issued with div_type = 10.
- Backpressure: hold resp_ready = 0 for 5 cycles after resp_valid -> resp_data and resp_tag stable, req_ready = 0. On resp_ready = 1 -> IDLE next cycle, req_ready = 1.
- Flush: assert cpu_flush 3 cycles into MUL_WAIT -> no resp_valid, req_ready stays 0 until the cycle after mul_out_valid. A following MUL 3 × 5 -> resp_data 15.
- Busy unit plus reset: mul_busy = 1 in MUL_ISSUE -> mul_in_valid stays 0 until mul_busy falls. Assert rst during DIV_WAIT -> all outputs 0 next cycle; a late div_out_valid produces no response.

Source files
------------

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: sequences RV32M ops from execute into the multiplier/divider and returns results
// on a valid/ready response channel; divide-by-zero and signed overflow are answered locally.
module mdu_ctrl #(
    parameter int TAG_W    = 5,
    parameter bit FAST_DIV = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    input  logic             cpu_flush,
    output logic             mul_in_valid,
    output logic [1:0]       mul_type,
    output logic [31:0]      mul_multiplicand,
    output logic [31:0]      mul_multiplier,
    output logic             mul_cpu_busy,
    input  logic [31:0]      mul_out,
    input  logic             mul_out_valid,
    input  logic             mul_busy,
    output logic             div_in_valid,
    output logic [1:0]       div_type,
    output logic [31:0]      div_dividend,
    output logic [31:0]      div_divisor,
    input  logic [31:0]      div_out,
    input  logic             div_out_valid,
    input  logic             div_busy
);
    typedef enum logic [2:0] {IDLE, MUL_ISSUE, MUL_WAIT, DIV_ISSUE, DIV_WAIT, RESP, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [2:0]         funct3_q;
    logic [31:0]        rs1_q, rs2_q, data_q, data_d, fast_data;
    logic [TAG_W-1:0]   tag_q;
    logic               accept, div_zero, div_ovf, fast;

    assign req_ready = (state_q == IDLE) && !cpu_flush && !rst;
    assign accept    = req_valid && req_ready;
    assign div_zero  = req_rs2 == 32'h0;
    assign div_ovf   = !req_funct3[0] && req_rs1 == 32'h8000_0000 && req_rs2 == 32'hFFFF_FFFF;
    assign fast      = FAST_DIV && (div_zero || div_ovf);
    assign fast_data = div_zero ? (req_funct3[1] ? req_rs1 : 32'hFFFF_FFFF)
                                : (req_funct3[1] ? 32'h0 : 32'h8000_0000);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: if (accept) begin
                if (!req_funct3[2]) state_d = MUL_ISSUE;
                else if (fast) begin
                    state_d = RESP;
                    data_d  = fast_data;
                end else state_d = DIV_ISSUE;
            end
            MUL_ISSUE: state_d = cpu_flush ? IDLE : (!mul_busy ? MUL_WAIT : MUL_ISSUE);
            DIV_ISSUE: state_d = cpu_flush ? IDLE : (!div_busy ? DIV_WAIT : DIV_ISSUE);
            // A result arriving with the flush is itself the drained result.
            MUL_WAIT: if (cpu_flush) state_d = mul_out_valid ? IDLE : DRAIN;
                else if (mul_out_valid) begin
                    state_d = RESP;
                    data_d  = mul_out;
                end
            DIV_WAIT: if (cpu_flush) state_d = div_out_valid ? IDLE : DRAIN;
                else if (div_out_valid) begin
                    state_d = RESP;
                    data_d  = div_out;
                end
            RESP:  state_d = (cpu_flush || resp_ready) ? IDLE : RESP;
            DRAIN: state_d = (funct3_q[2] ? div_out_valid : mul_out_valid) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            funct3_q <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            tag_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            if (accept) begin
                funct3_q <= req_funct3;
                rs1_q    <= req_rs1;
                rs2_q    <= req_rs2;
                tag_q    <= req_tag;
            end
        end
    end

    assign resp_valid       = state_q == RESP;
    assign resp_data        = data_q;
    assign resp_tag         = tag_q;
    assign mul_in_valid     = state_q == MUL_ISSUE && !mul_busy && !cpu_flush;
    assign mul_type         = funct3_q[1:0];
    assign mul_multiplicand = rs1_q;
    assign mul_multiplier   = rs2_q;
    assign mul_cpu_busy     = 1'b0;
    assign div_in_valid     = state_q == DIV_ISSUE && !div_busy && !cpu_flush;
    assign div_type         = funct3_q[1:0];
    assign div_dividend     = rs1_q;
    assign div_divisor      = rs2_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed checks of mdu_ctrl; the bench plays both arithmetic units.
module tb_mdu_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_valid_s = 1'b0, resp_ready = 1'b0, cpu_flush = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_rs1 = '0, req_rs2 = '0, mul_out = '0, div_out = '0;
    logic [4:0]  req_tag = '0;
    logic        mul_out_valid = 1'b0, mul_busy = 1'b0, div_out_valid = 1'b0, div_busy = 1'b0;

    logic        req_ready, resp_valid, mul_in_valid, mul_cpu_busy, div_in_valid;
    logic [31:0] resp_data, mul_multiplicand, mul_multiplier, div_dividend, div_divisor;
    logic [4:0]  resp_tag;
    logic [1:0]  mul_type, div_type;

    logic        s_req_ready, s_resp_valid, s_mul_in_valid, s_mul_cpu_busy, s_div_in_valid;
    logic [31:0] s_resp_data, s_mul_multiplicand, s_mul_multiplier, s_div_dividend, s_div_divisor;
    logic [4:0]  s_resp_tag;
    logic [1:0]  s_mul_type, s_div_type;

    int checks = 0, failures = 0, mul_pulses = 0, div_pulses = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mul_pulses <= mul_pulses + (mul_in_valid ? 1 : 0);
        div_pulses <= div_pulses + (div_in_valid ? 1 : 0);
    end

    mdu_ctrl #(.TAG_W(5), .FAST_DIV(1'b1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .cpu_flush(cpu_flush), .mul_in_valid(mul_in_valid),
        .mul_type(mul_type), .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
        .mul_cpu_busy(mul_cpu_busy), .mul_out(mul_out), .mul_out_valid(mul_out_valid),
        .mul_busy(mul_busy), .div_in_valid(div_in_valid), .div_type(div_type),
        .div_dividend(div_dividend), .div_divisor(div_divisor), .div_out(div_out),
        .div_out_valid(div_out_valid), .div_busy(div_busy)
    );

    mdu_ctrl #(.TAG_W(5), .FAST_DIV(1'b0)) u_slow (
        .clk(clk), .rst(rst), .req_valid(req_valid_s), .req_ready(s_req_ready),
        .req_funct3(req_funct3), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .resp_valid(s_resp_valid), .resp_ready(resp_ready), .resp_data(s_resp_data),
        .resp_tag(s_resp_tag), .cpu_flush(cpu_flush), .mul_in_valid(s_mul_in_valid),
        .mul_type(s_mul_type), .mul_multiplicand(s_mul_multiplicand),
        .mul_multiplier(s_mul_multiplier), .mul_cpu_busy(s_mul_cpu_busy), .mul_out(mul_out),
        .mul_out_valid(mul_out_valid), .mul_busy(mul_busy), .div_in_valid(s_div_in_valid),
        .div_type(s_div_type), .div_dividend(s_div_dividend), .div_divisor(s_div_divisor),
        .div_out(div_out), .div_out_valid(div_out_valid), .div_busy(div_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] tag);
        req_funct3 = f3;
        req_rs1    = a;
        req_rs2    = b;
        req_tag    = tag;
    endtask

    // Full multiply round trip; the bench supplies res as the multiplier's answer.
    task automatic do_mul(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input logic [31:0] res);
        int p0;
        p0 = mul_pulses;
        drive_req(f3, a, b, tag);
        req_valid = 1'b1;
        chk({nm, "_ready"}, req_ready, 1);
        step();
        req_valid = 1'b0;
        chk({nm, "_start"}, mul_in_valid, 1);
        chk({nm, "_type"}, mul_type, f3[1:0]);
        chk({nm, "_ops"}, {mul_multiplicand, mul_multiplier}, {a, b});
        step();
        chk({nm, "_start_gone"}, mul_in_valid, 0);
        mul_out = res;
        mul_out_valid = 1'b1;
        step();
        mul_out_valid = 1'b0;
        mul_out = 32'hDEAD_BEEF;
        step();
        chk({nm, "_resp"}, {resp_valid, resp_data, resp_tag}, {1'b1, res, tag});
        chk({nm, "_pulses"}, mul_pulses - p0, 1);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk({nm, "_idle"}, {resp_valid, req_ready}, 2'b01);
    endtask

    task automatic do_fast(input string nm, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag, input logic [31:0] res);
        int p0;
        p0 = div_pulses;
        drive_req(f3, a, b, tag);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk({nm, "_resp"}, {resp_valid, resp_data, resp_tag}, {1'b1, res, tag});
        chk({nm, "_no_div"}, div_in_valid, 0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk({nm, "_pulses"}, div_pulses - p0, 0);
    endtask

    initial begin
        step();
        step();
        chk("rst_outs", {req_ready, resp_valid, mul_in_valid, div_in_valid, resp_data, resp_tag}, 0);
        rst = 1'b0;
        step();
        chk("rst_ready", req_ready, 1);

        do_mul("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE);
        do_mul("mulh",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000);
        do_mul("mul",   3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0001);

        do_fast("div0",  3'b100, 32'd7, 32'd0, 5'd3, 32'hFFFF_FFFF);
        do_fast("remu0", 3'b111, 32'd7, 32'd0, 5'd4, 32'd7);
        do_fast("remov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'h0);
        do_fast("divov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000);

        // Same overflow case on the FAST_DIV=0 instance goes to the divider.
        drive_req(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        req_valid_s = 1'b1;
        step();
        req_valid_s = 1'b0;
        chk("slow_issue", {s_div_in_valid, s_div_type}, 3'b110);
        step();
        div_out = 32'h0;
        div_out_valid = 1'b1;
        step();
        div_out_valid = 1'b0;
        chk("slow_resp", {s_resp_valid, s_resp_data, s_resp_tag}, {1'b1, 32'h0, 5'd11});
        chk("main_ignores", {resp_valid, req_ready}, 2'b01);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("slow_idle", s_req_ready, 1);

        // Backpressure on the response channel.
        drive_req(3'b000, 32'd2, 32'd3, 5'd9);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        mul_out = 32'd6;
        mul_out_valid = 1'b1;
        step();
        mul_out_valid = 1'b0;
        mul_out = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {resp_valid, req_ready, resp_data, resp_tag}, {2'b10, 32'd6, 5'd9});
            step();
        end
        resp_ready = 1'b1;
        chk("bp_still", resp_valid, 1);
        step();
        resp_ready = 1'b0;
        chk("bp_release", {resp_valid, req_ready}, 2'b01);

        // Flush three cycles into MUL_WAIT, then drain.
        drive_req(3'b000, 32'd9, 32'd9, 5'd12);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        step();
        cpu_flush = 1'b1;
        step();
        cpu_flush = 1'b0;
        chk("fl_drain", {resp_valid, req_ready}, 2'b00);
        step();
        step();
        chk("fl_wait", {resp_valid, req_ready}, 2'b00);
        mul_out = 32'd1234;
        mul_out_valid = 1'b1;
        step();
        mul_out_valid = 1'b0;
        chk("fl_done", {resp_valid, req_ready}, 2'b01);
        step();
        chk("fl_no_resp", resp_valid, 0);
        do_mul("mul3x5", 3'b000, 32'd3, 32'd5, 5'd13, 32'd15);

        // Busy multiplier holds off the start pulse.
        mul_busy = 1'b1;
        drive_req(3'b000, 32'd4, 32'd4, 5'd14);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("busy_hold0", mul_in_valid, 0);
        step();
        chk("busy_hold1", mul_in_valid, 0);
        mul_busy = 1'b0;
        #1;
        chk("busy_go", mul_in_valid, 1);
        step();
        chk("busy_one", mul_in_valid, 0);
        mul_out = 32'd16;
        mul_out_valid = 1'b1;
        step();
        mul_out_valid = 1'b0;
        step();
        chk("busy_resp", {resp_valid, resp_data, resp_tag}, {1'b1, 32'd16, 5'd14});
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // Reset during DIV_WAIT; a late result must be ignored.
        drive_req(3'b100, 32'd100, 32'd7, 5'd15);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("rdiv_issue", {div_in_valid, div_type}, 3'b100);
        step();
        rst = 1'b1;
        step();
        chk("rdiv_outs", {req_ready, resp_valid, div_in_valid, mul_in_valid, resp_data, resp_tag,
                          div_type, mul_type, div_dividend}, 0);
        rst = 1'b0;
        div_out = 32'd14;
        div_out_valid = 1'b1;
        step();
        div_out_valid = 1'b0;
        chk("rdiv_late", {resp_valid, req_ready}, 2'b01);
        step();
        chk("rdiv_quiet", resp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
